// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants for the memory-bus initiator.
// Holds default bus widths, the strobe counter width and the FSM state
// encoding used by mem_bus_master (read-back states only matter when
// MEM_BUS_MASTER_READBACK_EN is defined).
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int STB_CNT_W  = 4;   // strobe width counter, STROBE_CYC 1..15

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_SETUP     = 3'd1;
  localparam logic [ST_W-1:0] ST_STROBE    = 3'd2;
  localparam logic [ST_W-1:0] ST_HOLD      = 3'd3;
  localparam logic [ST_W-1:0] ST_RB_SETUP  = 3'd4;
  localparam logic [ST_W-1:0] ST_RB_STROBE = 3'd5;
  localparam logic [ST_W-1:0] ST_RB_HOLD   = 3'd6;

  function automatic logic is_strobe_state(input logic [ST_W-1:0] st);
    return (st == ST_STROBE) || (st == ST_RB_STROBE);
  endfunction

endpackage

// File: rtl/mem_strobe_timer.sv
// mem_strobe_timer: loadable down-counter timing the strobe phase.
// Latency: o_tc is high in the cycle the count equals 1 (last strobe cycle).
// Backpressure: none; i_load wins over i_dec, count saturates at 0.
// Ports: clk/reset (sync, active-high), i_load + i_load_val load the count,
//        i_dec decrements, o_tc flags the final counted cycle.
module mem_strobe_timer
  import mem_bus_pkg::*;
#(
  parameter int W = STB_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the shared async-RAM bus (SETUP/STROBE/HOLD).
// Latency: done 2+STROBE_CYC cycles after req is taken; one txn per 3+STROBE_CYC.
// Backpressure: req only sampled in IDLE; req_* ignored while busy.
// Ports: clk, reset (sync, active-high); req/req_we/req_addr/req_wdata from the
//        sequencer; busy/done/rdata/err back to it; mem_addr/mem_read/mem_write
//        and tri-state data to the RAM. STROBE_CYC legal range 1..15.
// Option: MEM_BUS_MASTER_READBACK_EN adds a verify read after every write and
//         drives err; without it err is tied low and no read-back logic exists.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [STB_CNT_W-1:0] LP_STB = STB_CNT_W'(STROBE_CYC);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_nxt_state;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_oe;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_we_nxt;
  logic              w_tc;
  logic              w_load;
  logic              w_dec;
  logic              w_done_nxt;

`ifdef MEM_BUS_MASTER_READBACK_EN
  logic              r_err;
  // High in the first RB_SETUP cycle: gives the bus a dead cycle between the
  // master releasing data and the responder starting to drive it.
  logic              r_rb_wait;
`endif

  assign w_accept = (r_state == ST_IDLE) && req;
  // Direction for the state being entered; on accept the latch is not yet loaded.
  assign w_we_nxt = w_accept ? req_we : r_we;

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:   if (req) w_nxt_state = ST_SETUP;
      ST_SETUP:  w_nxt_state = ST_STROBE;
      ST_STROBE: if (w_tc) w_nxt_state = ST_HOLD;
`ifdef MEM_BUS_MASTER_READBACK_EN
      ST_HOLD:      w_nxt_state = r_we ? ST_RB_SETUP : ST_IDLE;
      ST_RB_SETUP:  if (!r_rb_wait) w_nxt_state = ST_RB_STROBE;
      ST_RB_STROBE: if (w_tc) w_nxt_state = ST_RB_HOLD;
      ST_RB_HOLD:   w_nxt_state = ST_IDLE;
`else
      ST_HOLD:   w_nxt_state = ST_IDLE;
`endif
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  // Timer loads on entry to a strobe phase and counts down while in it.
  assign w_load = is_strobe_state(w_nxt_state) && !is_strobe_state(r_state);
  assign w_dec  = is_strobe_state(r_state);

`ifdef MEM_BUS_MASTER_READBACK_EN
  // A write reports completion only after its verify read.
  assign w_done_nxt = (w_nxt_state == ST_RB_HOLD) ||
                      ((w_nxt_state == ST_HOLD) && !w_we_nxt);
`else
  assign w_done_nxt = (w_nxt_state == ST_HOLD);
`endif

  mem_strobe_timer #(.W(STB_CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (LP_STB),
    .i_dec      (w_dec),
    .o_tc       (w_tc)
  );

  // Bus controls are registered from the next state so they are glitch-free
  // and line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) begin
        r_we       <= req_we;
        r_wdata    <= req_wdata;
        r_mem_addr <= req_addr;
      end
      r_busy      <= (w_nxt_state != ST_IDLE);
      r_mem_write <= (w_nxt_state == ST_STROBE) && w_we_nxt;
      r_mem_read  <= ((w_nxt_state == ST_STROBE) && !w_we_nxt) ||
                     (w_nxt_state == ST_RB_STROBE);
      r_oe        <= w_we_nxt && ((w_nxt_state == ST_SETUP) ||
                                  (w_nxt_state == ST_STROBE) ||
                                  (w_nxt_state == ST_HOLD));
      r_done      <= w_done_nxt;
      // Sample on the edge that ends the last read strobe cycle.
      if ((r_state == ST_STROBE) && !r_we && w_tc) begin
        r_rdata <= data;
      end
    end
  end

`ifdef MEM_BUS_MASTER_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err     <= 1'b0;
      r_rb_wait <= 1'b0;
    end else begin
      r_rb_wait <= (r_state == ST_HOLD);
      if ((r_state == ST_RB_STROBE) && w_tc) begin
        r_err <= (data != r_wdata);
      end
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign data      = r_oe ? r_wdata : {DATA_W{1'bz}};
  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: self-checking bench for mem_bus_master.
// Instance dut uses STROBE_CYC=1 with a RAM model whose word 0x11 always reads
// 0x00; instance dut3 uses STROBE_CYC=3 for the back-to-back sequence.
module tb_mem_bus_master;

`ifdef MEM_BUS_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [4:0] STUCK_ADDR = 5'h11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A (STROBE_CYC=1)
  logic       req_a, we_a;
  logic [4:0] addr_a;
  logic [7:0] wdata_a;
  logic       busy_a, done_a, err_a, mem_read_a, mem_write_a;
  logic [7:0] rdata_a;
  logic [4:0] mem_addr_a;
  wire  [7:0] data_a;

  // instance 3 (STROBE_CYC=3)
  logic       req_3, we_3;
  logic [4:0] addr_3;
  logic [7:0] wdata_3;
  logic       busy_3, done_3, err_3, mem_read_3, mem_write_3;
  logic [7:0] rdata_3;
  logic [4:0] mem_addr_3;
  wire  [7:0] data_3;

  mem_bus_master #(.ADDR_W(5), .DATA_W(8), .STROBE_CYC(1)) dut (
    .clk(clk), .reset(reset), .req(req_a), .req_we(we_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .busy(busy_a), .done(done_a), .rdata(rdata_a),
    .err(err_a), .mem_addr(mem_addr_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .data(data_a)
  );

  mem_bus_master #(.ADDR_W(5), .DATA_W(8), .STROBE_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .req(req_3), .req_we(we_3), .req_addr(addr_3),
    .req_wdata(wdata_3), .busy(busy_3), .done(done_3), .rdata(rdata_3),
    .err(err_3), .mem_addr(mem_addr_3), .mem_read(mem_read_3),
    .mem_write(mem_write_3), .data(data_3)
  );

  // Asynchronous RAM responders: drive data while read is high, store on the
  // rising edge of the write strobe.
  logic [7:0] mem_a [32];
  logic [7:0] mem_3 [32];
  assign data_a = mem_read_a ? ((mem_addr_a == STUCK_ADDR) ? 8'h00 : mem_a[mem_addr_a]) : 8'bz;
  assign data_3 = mem_read_3 ? mem_3[mem_addr_3] : 8'bz;
  always @(posedge mem_write_a) mem_a[mem_addr_a] = data_a;
  always @(posedge mem_write_3) mem_3[mem_addr_3] = data_3;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pushed when a request is issued, popped on done.
  typedef struct {
    logic       is_read;
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t sb[$];
  logic last_err = 1'b0;

  always @(posedge clk) begin
    exp_t me;
    #1;
    if (done_a === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL done_pulse: actual=1 required=0 (no transaction outstanding)");
      end else begin
        me = sb.pop_front();
        if (me.is_read) chk("rdata", {24'b0, rdata_a}, {24'b0, me.rdata});
        chk("err", {31'b0, err_a}, {31'b0, me.err});
      end
    end
  end

  // Expected {busy, mem_write, mem_read, oe, done} for cycle c after req edge.
  function automatic logic [4:0] exp_ctl(input int c, input logic we);
    logic [4:0] r;
    r = 5'b0;
    if (we && RB) begin
      case (c)
        1, 3:    r = 5'b10010;
        2:       r = 5'b11010;
        4, 5:    r = 5'b10000;
        6:       r = 5'b10100;
        7:       r = 5'b10001;
        default: r = 5'b00000;
      endcase
    end else begin
      case (c)
        1:       r = {1'b1, 1'b0, 1'b0, we, 1'b0};
        2:       r = {1'b1, we, ~we, we, 1'b0};
        3:       r = {1'b1, 1'b0, 1'b0, we, 1'b1};
        default: r = 5'b00000;
      endcase
    end
    return r;
  endfunction

  // One transaction on instance A, called in an IDLE cycle at posedge+1.
  task automatic run_txn(input logic we, input logic [4:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
    exp_t e;
    int   n;
    if (we) last_err = RB && (addr == STUCK_ADDR) && (wdata != 8'h00);
    e.is_read = ~we;
    e.rdata   = exp_rd;
    e.err     = last_err;
    sb.push_back(e);
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
    n = (we && RB) ? 8 : 4;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == 1) begin
        // Scramble inputs: the latched copy must be used from here on.
        req_a = 1'b0; we_a = ~we; addr_a = ~addr; wdata_a = ~wdata;
      end
      chk($sformatf("ctl c%0d a%0h", c, addr),
          {27'b0, busy_a, mem_write_a, mem_read_a, dut.r_oe, done_a},
          {27'b0, exp_ctl(c, we)});
      if (c == 1) chk("mem_addr", {27'b0, mem_addr_a}, {27'b0, addr});
      if (we && c <= 3) chk($sformatf("wbus c%0d", c), {24'b0, data_a}, {24'b0, wdata});
      if (!we && c == 2) chk("rbus", {24'b0, data_a}, {24'b0, exp_rd});
    end
    chk("mem_addr idle", {27'b0, mem_addr_a}, {27'b0, addr});
    if (we) chk("ram word", {24'b0, mem_a[addr]}, {24'b0, wdata});
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;
  vec_t tbl[9];

  // STROBE_CYC=3 back-to-back: read 0x07 then write 0x08 with req held high.
  logic s_rd[21], s_wr[21], s_busy[21], s_done[21], s_oe[21];

  task automatic run_b2b();
    int rd_first, rd_cnt, wr_first, wr_cnt, ovl, rise1, rise2, d1, d2;
    rd_first = -1; rd_cnt = 0; wr_first = -1; wr_cnt = 0; ovl = 0;
    rise1 = -1; rise2 = -1; d1 = -1; d2 = -1;
    s_busy[0] = busy_3; s_rd[0] = 1'b0; s_wr[0] = 1'b0; s_done[0] = 1'b0; s_oe[0] = 1'b0;
    req_3 = 1'b1; we_3 = 1'b0; addr_3 = 5'h07; wdata_3 = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin we_3 = 1'b1; addr_3 = 5'h08; wdata_3 = 8'hE1; end
      if (c == 7) req_3 = 1'b0;
      s_rd[c] = mem_read_3; s_wr[c] = mem_write_3; s_busy[c] = busy_3;
      s_done[c] = done_3; s_oe[c] = dut3.r_oe;
    end
    for (int c = 1; c <= 20; c++) begin
      if (c <= 6 && s_rd[c]) begin rd_cnt++; if (rd_first < 0) rd_first = c; end
      if (c >= 7 && c <= 12 && s_wr[c]) begin wr_cnt++; if (wr_first < 0) wr_first = c; end
      if ((s_rd[c] && s_wr[c]) || (s_rd[c] && s_oe[c])) ovl++;
      if (s_busy[c] && !s_busy[c-1]) begin if (rise1 < 0) rise1 = c; else if (rise2 < 0) rise2 = c; end
      if (s_done[c]) begin if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
    end
    chk("sc3 setup1", rise1, 1);
    chk("sc3 setup2", rise2, 7);
    chk("sc3 rd first", rd_first, 2);
    chk("sc3 rd width", rd_cnt, 3);
    chk("sc3 wr first", wr_first, 8);
    chk("sc3 wr width", wr_cnt, 3);
    chk("sc3 overlap", ovl, 0);
    chk("sc3 done1", d1, 5);
    chk("sc3 done2", d2, RB ? 17 : 11);
    chk("sc3 rdata", {24'b0, rdata_3}, 32'h47);
    chk("sc3 ram", {24'b0, mem_3[8]}, 32'hE1);
    chk("sc3 err", {31'b0, err_3}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'h40 + 8'(i);
      mem_3[i] = 8'h40 + 8'(i);
    end
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_3 = 1'b0; we_3 = 1'b0; addr_3 = '0; wdata_3 = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();

    chk("rst ctl", {27'b0, busy_a, mem_write_a, mem_read_a, dut.r_oe, done_a}, 32'h0);
    chk("rst rdata", {24'b0, rdata_a}, 32'h0);
    chk("rst err", {31'b0, err_a}, 32'h0);
    chk("rst mem_addr", {27'b0, mem_addr_a}, 32'h0);
    chk("rst ctl3", {28'b0, busy_3, mem_write_3, mem_read_3, done_3}, 32'h0);

    tbl[0] = '{1'b1, 5'h0A, 8'h5C, 8'h00};
    tbl[1] = '{1'b0, 5'h0A, 8'h00, 8'h5C};
    tbl[2] = '{1'b1, 5'h03, 8'hC3, 8'h00};
    tbl[3] = '{1'b0, 5'h03, 8'h00, 8'hC3};
    tbl[4] = '{1'b0, 5'h1F, 8'h00, 8'h5F};
    tbl[5] = '{1'b1, 5'h11, 8'hA5, 8'h00};
    tbl[6] = '{1'b0, 5'h0A, 8'h00, 8'h5C};
    tbl[7] = '{1'b1, 5'h12, 8'h5A, 8'h00};
    tbl[8] = '{1'b0, 5'h12, 8'h00, 8'h5A};
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
    end

    // Reset during the strobe of a write to 0x1F.
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'h1F; wdata_a = 8'h99;
    tick();
    req_a = 1'b0;
    tick();
    chk("abort strobe", {31'b0, mem_write_a}, 32'h1);
    reset = 1'b1;
    tick();
    chk("abort ctl", {27'b0, busy_a, mem_write_a, mem_read_a, dut.r_oe, done_a}, 32'h0);
    chk("abort rdata", {24'b0, rdata_a}, 32'h0);
    tick();
    chk("abort done", {31'b0, done_a}, 32'h0);
    reset = 1'b0;
    last_err = 1'b0;
    tick();
    // The strobe's rising edge already stored 0x99 before the reset.
    run_txn(1'b0, 5'h1F, 8'h00, 8'h99);

    run_b2b();

    repeat (3) tick();
    chk("sb empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
